// File: rtl/sram_arb_pkg.sv
// Shared types for the sram arbiter: FSM state encoding, fill value and pointer sizing.
package sram_arb_pkg;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam int FILL_VALUE = 0;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant from a request vector, combinational; round-robin from i_ptr+1,
// or lowest index first when SRAM_ARB_FIXED_PRIO_EN is defined (no pointer port then).
module rr_arbiter import sram_arb_pkg::*; #(
   parameter  int NUM_REQ = 2,
   localparam int PW      = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
`ifndef SRAM_ARB_FIXED_PRIO_EN
   input  logic [PW-1:0]      i_ptr,
`endif
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PW-1:0]      o_idx
);

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      o_gnt = '0;
      o_idx = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         idx = PW'(i);
`else
         idx = PW'((int'(i_ptr) + 1 + i) % NUM_REQ);
`endif
         if (!found && i_req[idx]) begin
            found      = 1'b1;
            o_gnt[idx] = 1'b1;
            o_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port sram shared by NUM_REQ requesters: zero-fill after reset/clear, then one grant per
// cycle, read data returned one cycle after grant. SRAM_ARB_FIXED_PRIO_EN selects fixed priority.
module sram_arbiter import sram_arb_pkg::*; #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             init_done,
   output logic                             sram_we,
   output logic                             sram_oe,
   output logic [ADDR_WIDTH-1:0]            sram_addr,
   output logic [DATA_WIDTH-1:0]            sram_wdata,
   input  logic [DATA_WIDTH-1:0]            sram_rdata
);

   localparam int PW = ptr_width(NUM_REQ);

   state_t                 r_state;
   logic [ADDR_WIDTH-1:0]  r_fill_cnt;
   logic [NUM_REQ-1:0]     r_rsp_vld;
`ifndef SRAM_ARB_FIXED_PRIO_EN
   logic [PW-1:0]          r_rr_ptr;
`endif

   logic                   w_init;
   logic                   w_run;
   logic                   w_any;
   logic                   w_wr;
   logic                   w_rd;
   logic [NUM_REQ-1:0]     w_req;
   logic [NUM_REQ-1:0]     w_gnt;
   logic [PW-1:0]          w_idx;
   logic [ADDR_WIDTH-1:0]  w_addr;
   logic [DATA_WIDTH-1:0]  w_wdata;

   // clear suppresses the grant in its own cycle so the fill restarts from a quiet array
   assign w_init = rst_n && (r_state == ST_INIT);
   assign w_run  = rst_n && (r_state == ST_RUN) && !clear;
   assign w_req  = req_valid & {NUM_REQ{w_run}};

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req (w_req),
`ifndef SRAM_ARB_FIXED_PRIO_EN
      .i_ptr (r_rr_ptr),
`endif
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_any   = |w_gnt;
   assign w_wr    = w_any && req_we[w_idx];
   assign w_rd    = w_any && !req_we[w_idx];
   assign w_addr  = req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_wdata = req_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];

   assign req_ready  = w_gnt;
   assign sram_we    = w_init || w_wr;
   assign sram_oe    = w_rd;
   assign sram_addr  = w_init ? r_fill_cnt : (w_any ? w_addr : '0);
   assign sram_wdata = w_init ? DATA_WIDTH'(FILL_VALUE) : (w_wr ? w_wdata : '0);
   assign init_done  = rst_n && (r_state == ST_RUN);
   assign rsp_valid  = r_rsp_vld & {NUM_REQ{rst_n}};
   assign rsp_rdata  = (|rsp_valid) ? sram_rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_fill_cnt <= '0;
         r_rsp_vld  <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         r_rr_ptr   <= PW'(NUM_REQ - 1);
`endif
      end else begin
         r_rsp_vld <= w_rd ? w_gnt : '0;
         case (r_state)
            ST_INIT: begin
               if (clear) begin
                  r_fill_cnt <= '0;
               end else begin
                  r_fill_cnt <= r_fill_cnt + 1'b1;
                  if (r_fill_cnt == '1) r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (clear) begin
                  r_state    <= ST_INIT;
                  r_fill_cnt <= '0;
               end
`ifndef SRAM_ARB_FIXED_PRIO_EN
               else if (w_any) begin
                  r_rr_ptr <= w_idx;
               end
`endif
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic checked against a memory/arbitration model.
module tb_sram_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NR = 2;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_we = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]   req_ready, rsp_valid;
   logic [DW-1:0]   rsp_rdata, sram_wdata;
   logic [DW-1:0]   sram_rdata;
   logic            init_done, sram_we, sram_oe;
   logic [AW-1:0]   sram_addr;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   int            exp_ptr;
   bit            seeded;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
      .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // sram with registered read; seeded with non-zero junk so the zero-fill is observable
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(8'hF0 | i);
         seeded <= 1'b1;
      end else begin
         if (sram_oe) sram_rdata <= mem[sram_addr];
         if (sram_we) mem[sram_addr] <= sram_wdata;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int last);
      logic [NR-1:0] g;
      int c;
      g = '0;
      for (int k = 1; k <= NR; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         c = k - 1;
`else
         c = (last + k) % NR;
`endif
         if (v[c]) begin
            g[c] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic set_req(input int id, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[id] = v;
      req_we[id] = we;
      req_addr[id*AW +: AW] = a;
      req_wdata[id*DW +: DW] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear = 1'b0;
      set_req(0, 1'b1, 1'b1, 4'h3, 8'h77);
      set_req(1, 1'b1, 1'b0, 4'h9, 8'h00);
      for (int c = 0; c < 3; c++) begin
         tick();
         @(negedge clk);
         total++;
         if ({req_ready, rsp_valid, rsp_rdata, init_done, sram_we, sram_oe, sram_addr, sram_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b we=%b oe=%b addr=%h wd=%h done=%b want all zero",
                     req_ready, rsp_valid, sram_we, sram_oe, sram_addr, sram_wdata, init_done);
         end
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk);
         total++;
         if ({sram_we, sram_oe, sram_addr, sram_wdata, req_ready, init_done} !==
             {1'b1, 1'b0, AW'(c), 8'h00, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL init_fill[%0d]: got we=%b oe=%b addr=%h wd=%h rdy=%b done=%b want we=1 oe=0 addr=%h wd=00 rdy=00 done=0",
                     c, sram_we, sram_oe, sram_addr, sram_wdata, req_ready, init_done, AW'(c));
         end
         tick();
      end
      req_valid = '0;
      @(negedge clk);
      total++;
      if (init_done !== 1'b1) begin
         bad++;
         $display("FAIL init_done_at_16: got %b want 1", init_done);
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_ptr = NR - 1;
      tick();
   endtask

   task automatic test_read_all();
      int id, prev;
      prev = -1;
      for (int a = 0; a <= DEPTH; a++) begin
         req_valid = '0;
         id = $urandom_range(0, NR - 1);
         if (a < DEPTH) set_req(id, 1'b1, 1'b0, AW'(a), 8'h00);
         @(negedge clk);
         if (a < DEPTH) begin
            total++;
            if (req_ready !== NR'(1 << id) || sram_oe !== 1'b1 || sram_addr !== AW'(a)) begin
               bad++;
               $display("FAIL read_all_grant[%0d]: got rdy=%b oe=%b addr=%h want rdy=%b oe=1 addr=%h",
                        a, req_ready, sram_oe, sram_addr, NR'(1 << id), AW'(a));
            end
         end
         if (prev >= 0) begin
            total++;
            if (rsp_valid !== NR'(1 << prev) || rsp_rdata !== 8'h00) begin
               bad++;
               $display("FAIL read_all_rsp[%0d]: got rv=%b rd=%h want rv=%b rd=00",
                        a - 1, rsp_valid, rsp_rdata, NR'(1 << prev));
            end
         end
         prev = id;
         if (a < DEPTH) exp_ptr = id;
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_write_read();
      set_req(0, 1'b1, 1'b1, 4'h3, 8'hA5);
      @(negedge clk);
      total++;
      if ({req_ready, sram_we, sram_oe, sram_addr, sram_wdata} !== {2'b01, 1'b1, 1'b0, 4'h3, 8'hA5}) begin
         bad++;
         $display("FAIL wr_issue: got rdy=%b we=%b oe=%b addr=%h wd=%h want rdy=01 we=1 oe=0 addr=3 wd=a5",
                  req_ready, sram_we, sram_oe, sram_addr, sram_wdata);
      end
      tick();
      set_req(0, 1'b1, 1'b0, 4'h3, 8'h00);
      @(negedge clk);
      total++;
      if ({req_ready, sram_we, sram_oe, sram_addr, rsp_valid} !== {2'b01, 1'b0, 1'b1, 4'h3, 2'b00}) begin
         bad++;
         $display("FAIL rd_issue: got rdy=%b we=%b oe=%b addr=%h rv=%b want rdy=01 we=0 oe=1 addr=3 rv=00",
                  req_ready, sram_we, sram_oe, sram_addr, rsp_valid);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 8'hA5) begin
         bad++;
         $display("FAIL rd_rsp: got rv=%b rd=%h want rv=01 rd=a5", rsp_valid, rsp_rdata);
      end
      ref_mem[3] = 8'hA5;
      exp_ptr = 0;
      tick();
   endtask

`ifndef SRAM_ARB_FIXED_PRIO_EN
   task automatic test_alternate();
      logic [NR-1:0] exp_g, prev_g;
      set_req(0, 1'b1, 1'b1, 4'h1, 8'h11);
      @(negedge clk);
      tick();
      set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
      set_req(1, 1'b1, 1'b1, 4'h2, 8'h22);
      @(negedge clk);
      tick();
      set_req(0, 1'b1, 1'b0, 4'h1, 8'h00);
      set_req(1, 1'b1, 1'b0, 4'h2, 8'h00);
      prev_g = '0;
      for (int k = 0; k <= 8; k++) begin
         if (k == 8) req_valid = '0;
         exp_g = (k == 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
         @(negedge clk);
         total++;
         if (req_ready !== exp_g) begin
            bad++;
            $display("FAIL alt_grant[%0d]: got %b want %b", k, req_ready, exp_g);
         end
         if (k > 0) begin
            total++;
            if (rsp_valid !== prev_g || rsp_rdata !== ((prev_g == 2'b01) ? 8'h11 : 8'h22)) begin
               bad++;
               $display("FAIL alt_rsp[%0d]: got rv=%b rd=%h want rv=%b rd=%h", k, rsp_valid, rsp_rdata,
                        prev_g, (prev_g == 2'b01) ? 8'h11 : 8'h22);
            end
         end
         prev_g = exp_g;
         tick();
      end
      ref_mem[1] = 8'h11;
      ref_mem[2] = 8'h22;
      exp_ptr = 1;
   endtask

   task automatic test_same_cycle();
      set_req(0, 1'b1, 1'b1, 4'h7, 8'h5A);
      @(negedge clk);
      tick();
      set_req(1, 1'b1, 1'b1, 4'h5, 8'h3C);
      set_req(0, 1'b1, 1'b0, 4'h5, 8'h00);
      @(negedge clk);
      total++;
      if ({req_ready, sram_we, sram_oe, sram_addr, sram_wdata} !== {2'b10, 1'b1, 1'b0, 4'h5, 8'h3C}) begin
         bad++;
         $display("FAIL same_cycle_wr: got rdy=%b we=%b oe=%b addr=%h wd=%h want rdy=10 we=1 oe=0 addr=5 wd=3c",
                  req_ready, sram_we, sram_oe, sram_addr, sram_wdata);
      end
      tick();
      req_valid[1] = 1'b0;
      @(negedge clk);
      total++;
      if ({req_ready, sram_oe, sram_addr} !== {2'b01, 1'b1, 4'h5}) begin
         bad++;
         $display("FAIL same_cycle_rd: got rdy=%b oe=%b addr=%h want rdy=01 oe=1 addr=5", req_ready, sram_oe, sram_addr);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h3C) begin
         bad++;
         $display("FAIL same_cycle_rsp: got rv=%b rd=%h want rv=01 rd=3c", rsp_valid, rsp_rdata);
      end
      ref_mem[7] = 8'h5A;
      ref_mem[5] = 8'h3C;
      exp_ptr = 0;
      tick();
   endtask
`endif

   task automatic test_clear();
      set_req(0, 1'b1, 1'b0, 4'h3, 8'h00);
      @(negedge clk);
      tick();
      set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
      set_req(1, 1'b1, 1'b0, 4'h3, 8'h00);
      clear = 1'b1;
      @(negedge clk);
      total++;
      if ({req_ready, sram_we, sram_oe, rsp_valid, rsp_rdata} !== {2'b00, 1'b0, 1'b0, 2'b01, 8'hA5}) begin
         bad++;
         $display("FAIL clear_cycle: got rdy=%b we=%b oe=%b rv=%b rd=%h want rdy=00 we=0 oe=0 rv=01 rd=a5",
                  req_ready, sram_we, sram_oe, rsp_valid, rsp_rdata);
      end
      tick();
      clear = 1'b0;
      // a second clear at fill step 5 must restart the fill from address 0
      for (int c = 0; c < 6 + DEPTH; c++) begin
         int a;
         a = (c < 6) ? c : c - 6;
         clear = (c == 5);
         @(negedge clk);
         total++;
         if ({sram_we, sram_oe, sram_addr, sram_wdata, req_ready, init_done} !==
             {1'b1, 1'b0, AW'(a), 8'h00, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL clear_fill[%0d]: got we=%b addr=%h wd=%h rdy=%b done=%b want we=1 addr=%h wd=00 rdy=00 done=0",
                     c, sram_we, sram_addr, sram_wdata, req_ready, init_done, AW'(a));
         end
         tick();
      end
      clear = 1'b0;
      @(negedge clk);
      total++;
      if ({init_done, req_ready, sram_oe} !== {1'b1, 2'b10, 1'b1}) begin
         bad++;
         $display("FAIL clear_resume: got done=%b rdy=%b oe=%b want done=1 rdy=10 oe=1", init_done, req_ready, sram_oe);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h00) begin
         bad++;
         $display("FAIL clear_zeroed: got rv=%b rd=%h want rv=10 rd=00", rsp_valid, rsp_rdata);
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_ptr = 1;
      tick();
   endtask

`ifdef SRAM_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      set_req(0, 1'b1, 1'b1, 4'h8, 8'h01);
      set_req(1, 1'b1, 1'b1, 4'h9, 8'h02);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL fixed_prio[%0d]: got %b want 01", c, req_ready);
         end
         tick();
      end
      req_valid[0] = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL fixed_prio_drop: got %b want 10", req_ready);
      end
      tick();
      req_valid = '0;
      ref_mem[8] = 8'h01;
      ref_mem[9] = 8'h02;
   endtask
`endif

   task automatic test_random();
      logic [NR-1:0] eg, exp_rv;
      logic [DW-1:0] exp_rd;
      int g;
      // a read in flight when reset asserts must not produce a response
      set_req(0, 1'b1, 1'b0, 4'h3, 8'h00);
      @(negedge clk);
      tick();
      req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 8'h00) begin
         bad++;
         $display("FAIL reset_drops_rsp: got rv=%b rd=%h want rv=00 rd=00", rsp_valid, rsp_rdata);
      end
      tick();
      rst_n = 1'b1;
      repeat (DEPTH) tick();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_ptr = NR - 1;
      exp_rv = '0;
      exp_rd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int id = 0; id < NR; id++)
            if (!req_valid[id] && cyc < 399 && $urandom_range(0, 99) < 60)
               set_req(id, 1'b1, 1'(($urandom_range(0, 1))), AW'($urandom_range(0, 3)), DW'($urandom));
         eg = model_grant(req_valid, exp_ptr);
         @(negedge clk);
         total++;
         if (req_ready !== eg || (sram_we && sram_oe)) begin
            bad++;
            $display("FAIL rand_grant[%0d]: got rdy=%b we=%b oe=%b want rdy=%b", cyc, req_ready, sram_we, sram_oe, eg);
         end
         g = -1;
         for (int id = 0; id < NR; id++) if (eg[id]) g = id;
         if (g >= 0) begin
            total++;
            if (sram_we !== req_we[g] || sram_oe !== !req_we[g] || sram_addr !== req_addr[g*AW +: AW] ||
                (req_we[g] && sram_wdata !== req_wdata[g*DW +: DW])) begin
               bad++;
               $display("FAIL rand_sram[%0d]: got we=%b oe=%b addr=%h wd=%h want we=%b addr=%h wd=%h", cyc,
                        sram_we, sram_oe, sram_addr, sram_wdata, req_we[g], req_addr[g*AW +: AW], req_wdata[g*DW +: DW]);
            end
         end else begin
            total++;
            if (sram_we !== 1'b0 || sram_oe !== 1'b0) begin
               bad++;
               $display("FAIL rand_idle[%0d]: got we=%b oe=%b want 0 0", cyc, sram_we, sram_oe);
            end
         end
         total++;
         if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_rdata !== exp_rd)) begin
            bad++;
            $display("FAIL rand_rsp[%0d]: got rv=%b rd=%h want rv=%b rd=%h", cyc, rsp_valid, rsp_rdata, exp_rv, exp_rd);
         end
         exp_rv = '0;
         if (g >= 0) begin
            if (req_we[g]) ref_mem[req_addr[g*AW +: AW]] = req_wdata[g*DW +: DW];
            else begin
               exp_rv = eg;
               exp_rd = ref_mem[req_addr[g*AW +: AW]];
            end
            exp_ptr = g;
         end
         tick();
         if (g >= 0) req_valid[g] = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_read_all();
      test_write_read();
`ifndef SRAM_ARB_FIXED_PRIO_EN
      test_alternate();
      test_same_cycle();
`endif
      test_clear();
`ifdef SRAM_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
